fsgnj_arbiter: RTL and testbench

- Shares one registered sign-injection datapath (fsgnj / fsgnjn / fsgnjx) between two requesters, e.g. the FPU issue port and the divide/sqrt microsequencer.
- Round-robin arbitration, valid/ready handshakes on both sides, 2-cycle fixed latency.
- Full backpressure: results carry the originating port and a tag so the writeback stage can route them.

---
 rtl/fsgnj_arbiter.sv | 158 +++++++++++++++
 tb/tb_fsgnj_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsgnj_arbiter.sv
// ============================================================================
// Module   : fsgnj_arbiter
// Brief    : Two-port round-robin arbiter in front of a 2-stage registered
//            fsgnj/fsgnjn/fsgnjx datapath; optional counters via
//            FSGNJ_ARB_PERF_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fsgnj_arbiter #(
    parameter int TAG_W   = 5,
    parameter bit RR_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_funct,
    input  logic [31:0]      req0_x1,
    input  logic [31:0]      req0_x2,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_funct,
    input  logic [31:0]      req1_x1,
    input  logic [31:0]      req1_x2,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             res_port,
    output logic [TAG_W-1:0] res_tag,
`ifdef FSGNJ_ARB_PERF_EN
    output logic [31:0]      perf_grant0,
    output logic [31:0]      perf_grant1,
    output logic [31:0]      perf_stall,
`endif
    output logic             busy
);

    logic             r_ptr;
    logic             r_s1_valid;
    logic [1:0]       r_s1_funct;
    logic [31:0]      r_s1_x1;
    logic [31:0]      r_s1_x2;
    logic [TAG_W-1:0] r_s1_tag;
    logic             r_s1_port;
    logic             r_s2_valid;
    logic [31:0]      r_res_data;
    logic             r_res_port;
    logic [TAG_W-1:0] r_res_tag;

    logic w_s2_adv;
    logic w_s1_adv;
    logic w_grant0;
    logic w_grant1;
    logic w_grant;
    logic w_sign;

    assign w_s2_adv = !r_s2_valid || res_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;

    // A lone requester wins outright; on contention the pointer decides.
    assign w_grant0 = w_s1_adv && req0_valid && (!req1_valid || (r_ptr == 1'b0));
    assign w_grant1 = w_s1_adv && req1_valid && (!req0_valid || (r_ptr == 1'b1));
    assign w_grant  = w_grant0 || w_grant1;

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    always_comb begin
        w_sign = r_s1_x2[31];
        case (r_s1_funct)
            2'b00:   w_sign = r_s1_x2[31];
            2'b01:   w_sign = ~r_s1_x2[31];
            2'b10:   w_sign = r_s1_x1[31] ^ r_s1_x2[31];
            default: w_sign = r_s1_x1[31];
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr <= RR_INIT;
        end else if (w_grant0) begin
            r_ptr <= 1'b1;
        end else if (w_grant1) begin
            r_ptr <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_valid <= 1'b0;
            r_s1_funct <= 2'b00;
            r_s1_x1    <= 32'h0;
            r_s1_x2    <= 32'h0;
            r_s1_tag   <= '0;
            r_s1_port  <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= w_grant;
            if (w_grant) begin
                r_s1_funct <= w_grant1 ? req1_funct : req0_funct;
                r_s1_x1    <= w_grant1 ? req1_x1    : req0_x1;
                r_s1_x2    <= w_grant1 ? req1_x2    : req0_x2;
                r_s1_tag   <= w_grant1 ? req1_tag   : req0_tag;
                r_s1_port  <= w_grant1;
            end
        end
    end

    // Output register holds while stalled so the consumer sees a stable word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s2_valid <= 1'b0;
            r_res_data <= 32'h0;
            r_res_port <= 1'b0;
            r_res_tag  <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_res_data <= {w_sign, r_s1_x1[30:0]};
                r_res_port <= r_s1_port;
                r_res_tag  <= r_s1_tag;
            end
        end
    end

    assign res_valid = r_s2_valid;
    assign res_data  = r_res_data;
    assign res_port  = r_res_port;
    assign res_tag   = r_res_tag;
    assign busy      = r_s1_valid || r_s2_valid;

`ifdef FSGNJ_ARB_PERF_EN
    logic [31:0] r_perf_grant0;
    logic [31:0] r_perf_grant1;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_perf_grant0 <= 32'h0;
            r_perf_grant1 <= 32'h0;
            r_perf_stall  <= 32'h0;
        end else begin
            if (w_grant0)                 r_perf_grant0 <= r_perf_grant0 + 32'd1;
            if (w_grant1)                 r_perf_grant1 <= r_perf_grant1 + 32'd1;
            if (r_s2_valid && !res_ready) r_perf_stall  <= r_perf_stall + 32'd1;
        end
    end

    assign perf_grant0 = r_perf_grant0;
    assign perf_grant1 = r_perf_grant1;
    assign perf_stall  = r_perf_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fsgnj_arbiter.sv
// ============================================================================
// Module   : tb_fsgnj_arbiter
// Brief    : Self-checking bench for fsgnj_arbiter against a queue-based model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fsgnj_arbiter;

    localparam int TAG_W   = 5;
    localparam bit RR_INIT = 1'b0;

    logic             clk = 1'b0;
    logic             rstn;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [1:0]       req0_funct, req1_funct;
    logic [31:0]      req0_x1, req0_x2, req1_x1, req1_x2;
    logic [TAG_W-1:0] req0_tag, req1_tag;
    logic             res_valid, res_ready, res_port, busy;
    logic [31:0]      res_data;
    logic [TAG_W-1:0] res_tag;
`ifdef FSGNJ_ARB_PERF_EN
    logic [31:0]      perf_grant0, perf_grant1, perf_stall;
`endif

    always #5 clk = ~clk;

    fsgnj_arbiter #(.TAG_W(TAG_W), .RR_INIT(RR_INIT)) dut (
        .clk(clk), .rstn(rstn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_funct(req0_funct),
        .req0_x1(req0_x1), .req0_x2(req0_x2), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_funct(req1_funct),
        .req1_x1(req1_x1), .req1_x2(req1_x2), .req1_tag(req1_tag),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_port(res_port), .res_tag(res_tag),
`ifdef FSGNJ_ARB_PERF_EN
        .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_stall(perf_stall),
`endif
        .busy(busy)
    );

    // Model: ops in flight in arrival order; age = clock edges since grant.
    typedef struct {
        logic [31:0]      data;
        logic             port;
        logic [TAG_W-1:0] tag;
        int               age;
    } op_t;

    typedef struct {
        logic             port;
        logic [1:0]       funct;
        logic [31:0]      x1;
        logic [31:0]      x2;
        logic [TAG_W-1:0] tag;
        logic [31:0]      exp;
    } vec_t;

    op_t  mq[$];
    logic m_ptr;
    int   m_g0, m_g1, m_stall;
    logic g0, g1, a0, a1;
    int   n_pass, n_tot;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [31:0] ref_res(input logic [1:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        logic s;
        case (f)
            2'd0:    s = b[31];
            2'd1:    s = ~b[31];
            2'd2:    s = a[31] ^ b[31];
            default: s = a[31];
        endcase
        return {s, a[30:0]};
    endfunction

    // Called at a negedge with inputs set; checks, advances one clock, returns at next negedge.
    task automatic tick();
        logic shown, acc;
        #1;
        shown = (mq.size() > 0) && (mq[0].age >= 2);
        acc   = (mq.size() < 2) || res_ready;
        g0 = acc && req0_valid && (!req1_valid || m_ptr == 1'b0);
        g1 = acc && req1_valid && (!req0_valid || m_ptr == 1'b1);
        a0 = req0_ready;
        a1 = req1_ready;
        chk("res_valid", 32'(res_valid), 32'(shown));
        if (shown) begin
            chk("res_data", res_data, mq[0].data);
            chk("res_port", 32'(res_port), 32'(mq[0].port));
            chk("res_tag", 32'(res_tag), 32'(mq[0].tag));
        end
        chk("req0_ready", 32'(req0_ready), 32'(g0));
        chk("req1_ready", 32'(req1_ready), 32'(g1));
        chk("busy", 32'(busy), 32'(mq.size() > 0));
        @(posedge clk);
        if (rstn) begin
            if (shown && !res_ready) m_stall++;
            if (shown && res_ready) void'(mq.pop_front());
            foreach (mq[i]) mq[i].age++;
            if (g0) begin
                mq.push_back('{ref_res(req0_funct, req0_x1, req0_x2), 1'b0, req0_tag, 1});
                m_ptr = 1'b1; m_g0++;
            end
            if (g1) begin
                mq.push_back('{ref_res(req1_funct, req1_x1, req1_x2), 1'b1, req1_tag, 1});
                m_ptr = 1'b0; m_g1++;
            end
        end
        @(negedge clk);
    endtask

    task automatic new_op0();
        req0_funct = 2'($urandom); req0_x1 = $urandom; req0_x2 = $urandom;
        req0_tag = TAG_W'($urandom);
    endtask

    task automatic new_op1();
        req1_funct = 2'($urandom); req1_x1 = $urandom; req1_x2 = $urandom;
        req1_tag = TAG_W'($urandom);
    endtask

    task automatic stream_upd();
        if (g0) new_op0();
        if (g1) new_op1();
    endtask

    task automatic drain();
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
        for (int i = 0; i < 8 && mq.size() > 0; i++) tick();
        tick();
    endtask

    vec_t tbl[6];
    logic [31:0] held;

    initial begin
        n_pass = 0; n_tot = 0; m_g0 = 0; m_g1 = 0; m_stall = 0; m_ptr = RR_INIT;
        g0 = 0; g1 = 0; a0 = 0; a1 = 0;
        rstn = 1'b0; res_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        new_op0(); new_op1();

        tbl[0] = '{1'b0, 2'b00, 32'h3F800000, 32'h80000000, 5'd3,  32'hBF800000};
        tbl[1] = '{1'b1, 2'b00, 32'hC0490FDB, 32'h7F800000, 5'd7,  32'h40490FDB};
        tbl[2] = '{1'b1, 2'b01, 32'hC0490FDB, 32'h7F800000, 5'd8,  32'hC0490FDB};
        tbl[3] = '{1'b1, 2'b10, 32'hC0490FDB, 32'h7F800000, 5'd9,  32'hC0490FDB};
        tbl[4] = '{1'b1, 2'b11, 32'hC0490FDB, 32'h7F800000, 5'd10, 32'hC0490FDB};
        tbl[5] = '{1'b0, 2'b10, 32'hBF800000, 32'h80000000, 5'd31, 32'h3F800000};

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_res_tag", 32'(res_tag), 32'd0);
        chk("rst_res_port", 32'(res_port), 32'd0);
        rstn = 1'b1;
        tick();

        // Contention: 4 ops per port, both valid; grants must alternate from port 0
        begin
            int n0, n1, k;
            n0 = 0; n1 = 0; k = 0;
            req0_valid = 1'b1; req1_valid = 1'b1;
            for (int c = 0; c < 40 && (n0 < 4 || n1 < 4); c++) begin
                tick();
                if (a0 || a1) begin
                    chk("rr_order", {30'd0, a1, a0}, (k % 2 == 1) ? 32'd2 : 32'd1);
                    k++;
                end
                if (g0) begin n0++; new_op0(); if (n0 == 4) req0_valid = 1'b0; end
                if (g1) begin n1++; new_op1(); if (n1 == 4) req1_valid = 1'b0; end
            end
            chk("rr_total", 32'(k), 32'd8);
            drain();
        end

        // Directed vectors with explicit 2-cycle latency
        foreach (tbl[i]) begin
            int w;
            if (tbl[i].port) begin
                req1_valid = 1'b1; req1_funct = tbl[i].funct; req1_x1 = tbl[i].x1;
                req1_x2 = tbl[i].x2; req1_tag = tbl[i].tag;
            end else begin
                req0_valid = 1'b1; req0_funct = tbl[i].funct; req0_x1 = tbl[i].x1;
                req0_x2 = tbl[i].x2; req0_tag = tbl[i].tag;
            end
            w = 0;
            do begin tick(); w++; end while (!(g0 || g1) && w < 10);
            chk("tbl_granted", 32'(a0 || a1), 32'd1);
            req0_valid = 1'b0; req1_valid = 1'b0;
            tick();
            chk("tbl_valid", 32'(res_valid), 32'd1);
            chk("tbl_data", res_data, tbl[i].exp);
            chk("tbl_port", 32'(res_port), 32'(tbl[i].port));
            chk("tbl_tag", 32'(res_tag), 32'(tbl[i].tag));
            tick(); tick();
        end

        // Backpressure: 5 stalled cycles with both ports streaming
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin tick(); stream_upd(); end
        res_ready = 1'b0;
        held = res_data;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", res_data, held);
            tick(); stream_upd();
        end
        chk("bp_full_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        chk("bp_busy", 32'(busy), 32'd1);
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin tick(); stream_upd(); end
        drain();

        // Reset mid-flight with both stages full and pointer moved off RR_INIT
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(); stream_upd();
            if (m_ptr != RR_INIT && mq.size() == 2 && mq[0].age >= 2) break;
        end
        chk("pre_rst_busy", 32'(busy), 32'd1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rstn = 1'b0;
        #1;
        chk("rst_mid_res_valid", 32'(res_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        mq.delete(); m_ptr = RR_INIT; m_g0 = 0; m_g1 = 0; m_stall = 0;
        @(negedge clk);
        tick();
        rstn = 1'b1;
        tick(); tick();
        req0_valid = 1'b1; req1_valid = 1'b1; new_op0(); new_op1();
        tick();
        chk("rst_ptr_grant0", {30'd0, a1, a0}, 32'd1);
        stream_upd();
        tick(); stream_upd();
        drain();

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            if (!req0_valid && ($urandom % 3 != 0)) begin req0_valid = 1'b1; new_op0(); end
            if (!req1_valid && ($urandom % 3 != 0)) begin req1_valid = 1'b1; new_op1(); end
            res_ready = ($urandom % 4 != 0);
            tick();
            if (g0) req0_valid = 1'b0;
            if (g1) req1_valid = 1'b0;
        end
        drain();

`ifdef FSGNJ_ARB_PERF_EN
        chk("perf_grant0", perf_grant0, 32'(m_g0));
        chk("perf_grant1", perf_grant1, 32'(m_g1));
        chk("perf_stall", perf_stall, 32'(m_stall));
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

`default_nettype wire
